// File: rtl/dispatch_ctrl_pkg.sv
// dispatch_ctrl_pkg: shared types, opcode constants and FSM states for the dispatch stage
package dispatch_ctrl_pkg;
  typedef logic [31:0] DATA_TYPE;
  typedef logic [4:0] ROB_POS_TYPE;
  localparam DATA_TYPE ZERO_WORD = 32'h0;
  localparam logic [6:0] OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP = 7'b0110011;
  typedef enum logic [1:0] {IDLE, HOLD, FLUSH} state_t;
endpackage

// File: rtl/dispatch_classify.sv
// dispatch_classify: maps an opcode to its dispatch target (RS, LSB or unknown)
module dispatch_classify
  import dispatch_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       rs,
  output logic       lsb,
  output logic       unknown
);
  // pure opcode decode; anything not recognised is reported as unknown
  always_comb begin
    lsb = opcode == OPC_LOAD || opcode == OPC_STORE;
    rs = opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL || opcode == OPC_JALR ||
         opcode == OPC_BRANCH || opcode == OPC_OPIMM || opcode == OPC_OP;
    unknown = !(rs || lsb);
  end
endmodule

// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: one-entry buffer between fetcher and decoder with stall/drop accounting
module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        in_fetcher_valid,
  input  logic [31:0] in_fetcher_instr,
  input  logic [31:0] in_fetcher_pc,
  input  logic        in_fetcher_jump_flag,
  output logic        out_fetcher_ready,
  input  logic        in_rob_full,
  input  logic        in_rs_full,
  input  logic        in_lsb_full,
  input  logic        in_rob_rollback,
  output logic [31:0] out_dec_instr,
  output logic [31:0] out_dec_pc,
  output logic        out_dec_jump_flag,
  output logic        out_dec_valid,
  output logic [15:0] out_stall_count,
  output logic [7:0]  out_drop_count
);
  state_t state, state_d;
  DATA_TYPE buf_instr, buf_pc;
  logic buf_jump, is_rs, is_lsb, is_unknown, held, fire, accept;
  dispatch_classify u_classify (
    .opcode (buf_instr[6:0]),
    .rs     (is_rs),
    .lsb    (is_lsb),
    .unknown(is_unknown)
  );
  assign held = state == HOLD;
  assign fire = rdy && held && !in_rob_rollback && !in_rob_full &&
                (is_rs ? !in_rs_full : is_lsb && !in_lsb_full);
  assign out_fetcher_ready = rst && rdy && !in_rob_rollback && state != FLUSH && (state == IDLE || fire);
  assign accept = in_fetcher_valid && out_fetcher_ready;
  assign out_dec_valid = fire;
  assign out_dec_instr = fire ? buf_instr : ZERO_WORD;
  assign out_dec_pc = fire ? buf_pc : ZERO_WORD;
  assign out_dec_jump_flag = fire && buf_jump;
  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_d;
  end
  // next state: rollback wins, FLUSH is a single bubble, unknown opcodes fall back to IDLE
  always_comb begin
    state_d = state;
    if (rdy)
      state_d = in_rob_rollback ? FLUSH :
                state == FLUSH ? IDLE :
                state == IDLE ? (accept ? HOLD : IDLE) :
                (is_unknown || (fire && !accept)) ? IDLE : HOLD;
  end
  // instruction buffer: cleared on rollback, loaded on accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_instr <= ZERO_WORD;
      buf_pc <= ZERO_WORD;
      buf_jump <= 1'b0;
    end else if (rdy && in_rob_rollback) begin
      buf_instr <= ZERO_WORD;
      buf_pc <= ZERO_WORD;
      buf_jump <= 1'b0;
    end else if (accept) begin
      buf_instr <= in_fetcher_instr;
      buf_pc <= in_fetcher_pc;
      buf_jump <= in_fetcher_jump_flag;
    end
  end
  // saturating stall and drop counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_stall_count <= '0;
      out_drop_count <= '0;
    end else if (rdy) begin
      if (held && !is_unknown && !fire && out_stall_count != '1) out_stall_count <= out_stall_count + 16'd1;
      if (held && is_unknown && !in_rob_rollback && out_drop_count != '1) out_drop_count <= out_drop_count + 8'd1;
    end
  end
endmodule

// File: doc/dispatch_ctrl.md
DISPATCH_CTRL -- requirements
Module: dispatch_ctrl

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port rdy  input  1  global enable; low freezes all state and suppresses handshakes.
REQ-004 SHALL have port in_fetcher_valid  input  1  fetcher offers an instruction.
REQ-005 SHALL have port in_fetcher_instr  input  32  offered instruction word.
REQ-006 SHALL have port in_fetcher_pc  input  32  PC of the offered instruction.
REQ-007 SHALL have port in_fetcher_jump_flag  input  1  branch-predicted-taken flag of the offered instruction.
REQ-008 SHALL have port out_fetcher_ready  output  1  controller accepts the offer this cycle.
REQ-009 SHALL have ports in_rob_full, in_rs_full, in_lsb_full  input  1 each  target has no free entry this cycle.
REQ-010 SHALL have port in_rob_rollback  input  1  misprediction flush request.
REQ-011 SHALL have ports out_dec_instr, out_dec_pc  output  32 each  instruction and PC driven to the decoder.
REQ-012 SHALL have port out_dec_jump_flag  output  1  jump flag driven to the decoder.
REQ-013 SHALL have port out_dec_valid  output  1  dispatch fires this cycle.
REQ-014 SHALL have port out_stall_count  output  16  saturating count of stalled HOLD cycles.
REQ-015 SHALL have port out_drop_count  output  8  saturating count of discarded unknown-opcode instructions.

Function
REQ-016 SHALL implement states IDLE (buffer empty), HOLD (one instruction buffered), FLUSH (one-cycle post-rollback bubble).
REQ-017 SHALL classify the buffered opcode: 0000011/0100011 -> LSB; 0110111, 0010111, 1101111, 1100111, 1100011, 0010011, 0110011 -> RS; any other -> UNKNOWN.
REQ-018 SHALL define fire = rdy & HOLD & !rollback & !rob_full & (RS target ? !rs_full : !lsb_full); UNKNOWN never fires.
REQ-019 SHALL, on fire, drive out_dec_valid=1 and the buffered instr/pc/jump_flag combinationally in the same cycle.
REQ-020 SHALL, when not firing, drive out_dec_instr=32'h0, out_dec_pc=0, out_dec_jump_flag=0, out_dec_valid=0 (opcode 0 decodes to no allocation).
REQ-021 SHALL drive out_fetcher_ready = rdy & !rollback & state!=FLUSH & (IDLE | fire).
REQ-022 SHALL capture the offer into the buffer when in_fetcher_valid & out_fetcher_ready; minimum accept-to-fire latency is 1 cycle.
REQ-023 SHALL support back-to-back throughput: fire and accept in the same cycle keep HOLD with the new instruction.
REQ-024 SHALL go HOLD->IDLE on fire without accept; IDLE->HOLD on accept.
REQ-025 SHALL, for an UNKNOWN buffered opcode, discard it one cycle after capture (HOLD->IDLE, no fire) and increment out_drop_count.
REQ-026 SHALL increment out_stall_count in every rdy cycle in HOLD with a non-UNKNOWN instruction and fire=0; both counters saturate at all-ones.
REQ-027 SHALL give rollback priority over fire and accept: buffer invalidated, next state FLUSH; FLUSH always transitions to IDLE.
REQ-028 SHALL, when rdy=0, hold state, buffer and counters unchanged.

Reset
REQ-029 SHALL, on rst low, asynchronously enter IDLE, clear buffer to zero, clear both counters; all outputs 0 while reset asserted.
REQ-030 SHALL discard any buffered instruction when reset asserts mid-HOLD; no dispatch for it after release.

Structure
REQ-031 SHALL take opcode constants, DATA_TYPE, ROB_POS_TYPE, ZERO_WORD from the shared defines header; decoder opcode parameters move there too.
REQ-032 SHALL place classification in one combinational sub-module dispatch_classify (opcode in, {rs, lsb, unknown} out).

Verification
REQ-033 SHALL cover: ADDI 32'h00100093 offered, all not full -> accepted cycle 0, out_dec_valid=1 with same word cycle 1.
REQ-034 SHALL cover: LW 32'h00002083 buffered, in_lsb_full=1 for 3 cycles, in_rs_full=1 -> fires cycle 4, out_stall_count=3, ready=0 during stall.
REQ-035 SHALL cover: continuous offers, no full -> one fire per cycle, 10 instructions dispatched in order in 11 cycles.
REQ-036 SHALL cover: rollback during HOLD with ADD buffered -> no fire, FLUSH cycle with ready=0, IDLE next, buffered ADD never dispatched.
REQ-037 SHALL cover: word 32'hFFFFFFFF offered -> accepted, never fires, out_drop_count=1; 300 such -> saturates at 255.
REQ-038 SHALL cover: rst pulled low mid-HOLD asynchronously -> outputs 0 immediately, counters 0, IDLE after release.
